// File: rtl/eight_bit_divider.sv
// eight_bit_divider: sequential restoring divider, one quotient bit per clock.
//
// Operands are taken on a single-cycle Start strobe while idle. Each RUN
// cycle shifts {R,Q} left, trial-subtracts the divisor through a
// (WIDTH+1)-bit subtractor and restores on a negative trial. Results are
// committed on the eighth iteration; Done pulses for one cycle afterwards.
//
// Ports:
//   Clk        in   system clock, rising edge
//   Reset_n    in   asynchronous active-low reset
//   Start      in   request strobe, sampled only in IDLE
//   Dividend   in   numerator, captured on the accepting edge
//   Divisor    in   denominator, captured on the accepting edge
//   Quotient   out  result, held until the next commit
//   Remainder  out  result, held until the next commit
//   Busy       out  high from acceptance until DONE is left
//   Done       out  one-cycle completion pulse
//   DivZero    out  divisor was zero; cleared on the next accepted Start
//
// Build option: define DIVIDER_SIGNED_EN for two's complement operands
// (quotient truncates toward zero, remainder takes the dividend's sign).
// Without it the divider is unsigned and no sign logic exists.
module eight_bit_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned R_W   = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [R_W-1:0]     r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               divz_q, divz_d;

  // Iteration datapath
  logic [R_W-1:0]     r_shift;
  logic [R_W-1:0]     trial;
  logic               q_bit;
  logic [R_W-1:0]     r_next;
  logic [WIDTH-1:0]   q_next;

  // Operand conditioning and result fix-up
  logic [WIDTH-1:0]   load_a;
  logic [WIDTH-1:0]   load_b;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

`ifdef DIVIDER_SIGNED_EN
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
`endif

  // One restoring step: shift in the next dividend bit, trial-subtract D.
  always_comb begin
    r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial   = r_shift - {1'b0, d_q};
    q_bit   = ~trial[R_W-1];
    r_next  = q_bit ? trial : r_shift;
    q_next  = {q_q[WIDTH-2:0], q_bit};
  end

  // Magnitudes going in, sign correction coming out.
`ifdef DIVIDER_SIGNED_EN
  always_comb begin
    // Negating the most negative value yields 2^(WIDTH-1), which is the
    // correct unsigned magnitude, so no special case is needed.
    load_a  = Dividend[WIDTH-1] ? WIDTH'(-Dividend) : Dividend;
    load_b  = Divisor[WIDTH-1]  ? WIDTH'(-Divisor)  : Divisor;
    quo_fix = neg_q_q ? WIDTH'(-q_next) : q_next;
    rem_fix = neg_r_q ? WIDTH'(-r_next[WIDTH-1:0]) : r_next[WIDTH-1:0];
  end
`else
  always_comb begin
    load_a  = Dividend;
    load_b  = Divisor;
    quo_fix = q_next;
    rem_fix = r_next[WIDTH-1:0];
  end
`endif

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    divz_d  = divz_q;
`ifdef DIVIDER_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          r_d    = '0;
          d_d    = load_b;
          cnt_d  = '0;
          dz_d   = (Divisor == '0);
          divz_d = 1'b0;
          busy_d = 1'b1;
          // A zero divisor keeps the raw dividend so it can be returned
          // unchanged as the remainder.
          q_d    = (Divisor == '0) ? Dividend : load_a;
`ifdef DIVIDER_SIGNED_EN
          neg_q_d = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
          neg_r_d = Dividend[WIDTH-1];
`endif
          state_d = RUN;
        end
      end

      RUN: begin
        if (dz_q) begin
          // Divide-by-zero commits one edge after acceptance.
          quo_d   = '1;
          rem_d   = q_q;
          divz_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          r_d   = r_next;
          q_d   = q_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quo_d   = quo_fix;
            rem_d   = rem_fix;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
`ifdef DIVIDER_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivZero   = divz_q;

endmodule
